// File: rtl/lsu_seq.sv
//============================================================================
// Module   : lsu_seq
// Purpose  : Sequential big-endian load/store unit with read-modify-write of
//            sub-word stores against a single-port word RAM.
// Revision : 1.0  initial release
//============================================================================
`default_nettype none

module lsu_seq (
    input  logic        CLK,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [1:0] c_SZ_BYTE = 2'b00;
    localparam logic [1:0] c_SZ_HALF = 2'b01;
    localparam logic [1:0] c_SZ_WORD = 2'b10;
    localparam logic [1:0] c_SZ_ILL  = 2'b11;

    state_t      r_state;
    logic [1:0]  r_offset;
    logic [1:0]  r_size;
    logic        r_signed;
    logic        r_write;
    logic [31:0] r_wdata;

    logic        w_req_error;
    logic [4:0]  w_shift;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_mask;
    logic [31:0] w_load;
    logic [31:0] w_merged;

    assign w_req_error = (req_size == c_SZ_ILL)
                       | ((req_size == c_SZ_HALF) & req_addr[0])
                       | ((req_size == c_SZ_WORD) & (req_addr[1:0] != 2'b00));

    // Big-endian: lane at offset 0 sits in the most significant bits.
    always_comb begin
        w_shift = 5'd0;
        w_mask  = 32'hFFFF_FFFF;
        case (r_size)
            c_SZ_BYTE: begin
                w_shift = {~r_offset, 3'b000};
                w_mask  = 32'h0000_00FF << w_shift;
            end
            c_SZ_HALF: begin
                w_shift = {~r_offset[1], 4'b0000};
                w_mask  = 32'h0000_FFFF << w_shift;
            end
            default: begin
                w_shift = 5'd0;
                w_mask  = 32'hFFFF_FFFF;
            end
        endcase
    end

    assign w_byte   = 8'(mem_rdata >> w_shift);
    assign w_half   = 16'(mem_rdata >> w_shift);
    assign w_merged = (mem_rdata & ~w_mask) | ((r_wdata << w_shift) & w_mask);

    always_comb begin
        w_load = mem_rdata;
        case (r_size)
            c_SZ_BYTE: w_load = r_signed ? {{24{w_byte[7]}}, w_byte} : {24'd0, w_byte};
            c_SZ_HALF: w_load = r_signed ? {{16{w_half[15]}}, w_half} : {16'd0, w_half};
            default:   w_load = mem_rdata;
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_offset   <= 2'b00;
            r_size     <= 2'b00;
            r_signed   <= 1'b0;
            r_write    <= 1'b0;
            r_wdata    <= 32'd0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_error <= 1'b0;
            resp_rdata <= 32'd0;
            mem_addr   <= 32'd0;
            mem_wdata  <= 32'd0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_offset  <= req_addr[1:0];
                        r_size    <= req_size;
                        r_signed  <= req_signed;
                        r_write   <= req_write;
                        r_wdata   <= req_wdata;
                        req_ready <= 1'b0;
                        if (w_req_error) begin
                            r_state    <= RESP;
                            resp_valid <= 1'b1;
                            resp_error <= 1'b1;
                            resp_rdata <= 32'd0;
                        end else if (!req_write || (req_size != c_SZ_WORD)) begin
                            // Loads and sub-word stores both start with a read.
                            r_state  <= RD;
                            mem_read <= 1'b1;
                            mem_addr <= {req_addr[31:2], 2'b00};
                        end else begin
                            r_state   <= WR;
                            mem_write <= 1'b1;
                            mem_addr  <= {req_addr[31:2], 2'b00};
                            mem_wdata <= req_wdata;
                        end
                    end
                end
                RD: begin
                    mem_read <= 1'b0;
                    if (r_write) begin
                        r_state   <= WR;
                        mem_write <= 1'b1;
                        mem_wdata <= w_merged;
                    end else begin
                        r_state    <= RESP;
                        mem_addr   <= 32'd0;
                        resp_valid <= 1'b1;
                        resp_rdata <= w_load;
                    end
                end
                WR: begin
                    r_state    <= RESP;
                    mem_write  <= 1'b0;
                    mem_wdata  <= 32'd0;
                    mem_addr   <= 32'd0;
                    resp_valid <= 1'b1;
                    resp_rdata <= 32'd0;
                end
                RESP: begin
                    if (resp_ready) begin
                        r_state    <= IDLE;
                        resp_valid <= 1'b0;
                        resp_error <= 1'b0;
                        resp_rdata <= 32'd0;
                        req_ready  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lsu_seq.sv
//============================================================================
// Module   : tb_lsu_seq
// Purpose  : Self-checking bench for lsu_seq against a byte-addressed
//            big-endian memory model.
// Revision : 1.0  initial release
//============================================================================
`default_nettype none

module tb_lsu_seq;

    logic        CLK = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rdata;

    lsu_seq dut (
        .CLK(CLK), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_error(resp_error),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
        .mem_write(mem_write), .mem_rdata(mem_rdata)
    );

    always #5 CLK = ~CLK;

    // Physical 16-word RAM seen by the DUT; bench preload port shares the block.
    logic [31:0] ram [16];
    logic        tb_we = 1'b0;
    logic [3:0]  tb_idx = 4'd0;
    logic [31:0] tb_val = 32'd0;

    assign mem_rdata = ram[mem_addr[5:2]];

    always @(posedge CLK) begin
        if (tb_we)          ram[tb_idx] <= tb_val;
        else if (mem_write) ram[mem_addr[5:2]] <= mem_wdata;
    end

    // Reference memory: plain byte array, byte a+0 is the most significant.
    logic [7:0] mdl [64];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    endtask

    function automatic logic [31:0] mword(input int a);
        return {mdl[a], mdl[a+1], mdl[a+2], mdl[a+3]};
    endfunction

    task automatic init_word(input int w, input logic [31:0] v);
        @(negedge CLK);
        tb_we = 1'b1; tb_idx = 4'(w); tb_val = v;
        @(posedge CLK); #1;
        tb_we = 1'b0;
        for (int i = 0; i < 4; i++) mdl[4*w+i] = 8'(v >> (8*(3-i)));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_req_ready"},  req_ready,  1);
        check_eq({tag, "_resp_valid"}, resp_valid, 0);
        check_eq({tag, "_resp_error"}, resp_error, 0);
        check_eq({tag, "_mem_read"},   mem_read,   0);
        check_eq({tag, "_mem_write"},  mem_write,  0);
        check_eq({tag, "_resp_rdata"}, resp_rdata, 0);
        check_eq({tag, "_mem_addr"},   mem_addr,   0);
        check_eq({tag, "_mem_wdata"},  mem_wdata,  0);
    endtask

    task automatic wait_ready();
        int t = 0;
        @(negedge CLK);
        while (!req_ready && t < 20) begin @(negedge CLK); t++; end
        check_eq("req_ready_wait", req_ready, 1);
    endtask

    task automatic do_req(input bit wr, input logic [1:0] sz, input bit sg,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int stall, input bit intrude);
        int          ai = int'(a[5:0]);
        int          n  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        bit          err = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
        logic [31:0] al = {a[31:2], 2'b00};
        logic [31:0] exp_rd = 32'd0;
        logic [31:0] exp_ww = 32'd0;
        int          exp_lat, exp_nr, exp_nw, lat, nr, nw;

        if (err) begin
            exp_lat = 1; exp_nr = 0; exp_nw = 0;
        end else if (!wr) begin
            for (int i = 0; i < n; i++) exp_rd = {exp_rd[23:0], mdl[ai+i]};
            if (sg && n == 1 && exp_rd[7])  exp_rd |= 32'hFFFF_FF00;
            if (sg && n == 2 && exp_rd[15]) exp_rd |= 32'hFFFF_0000;
            exp_lat = 2; exp_nr = 1; exp_nw = 0;
        end else begin
            for (int i = 0; i < n; i++) mdl[ai+i] = 8'(wd >> (8*(n-1-i)));
            exp_ww  = mword(int'(al[5:0]));
            exp_lat = (n == 4) ? 2 : 3;
            exp_nr  = (n == 4) ? 0 : 1;
            exp_nw  = 1;
        end

        wait_ready();
        req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd;
        @(posedge CLK); #1;
        req_valid = 1'b0;
        lat = 1; nr = 0; nw = 0;
        forever begin
            if (mem_read) begin nr++; check_eq("rd_addr", mem_addr, al); end
            if (mem_write) begin
                nw++;
                check_eq("wr_addr", mem_addr, al);
                check_eq("wr_data", mem_wdata, exp_ww);
            end else begin
                check_eq("wdata_idle", mem_wdata, 0);
            end
            if (resp_valid || lat >= 8) break;
            @(posedge CLK); #1;
            lat++;
        end
        check_eq("latency", lat, exp_lat);
        check_eq("rdata", resp_rdata, exp_rd);
        check_eq("error", resp_error, err);
        check_eq("n_reads", nr, exp_nr);
        check_eq("n_writes", nw, exp_nw);

        if (intrude) begin
            req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_addr = 32'h10;
        end
        for (int k = 0; k < stall; k++) begin
            @(posedge CLK); #1;
            check_eq("stall_valid", resp_valid, 1);
            check_eq("stall_rdata", resp_rdata, exp_rd);
            check_eq("stall_error", resp_error, err);
            check_eq("stall_req_ready", req_ready, 0);
            check_eq("stall_mem_read", mem_read, 0);
        end
        resp_ready = 1'b1;
        @(posedge CLK); #1;
        resp_ready = 1'b0;
        check_eq("hs_valid", resp_valid, 0);
        check_eq("hs_req_ready", req_ready, 1);
        check_eq("hs_no_accept", mem_read, 0);
    endtask

    task automatic reset_mid(input int extra);
        wait_ready();
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_signed = 1'b0;
        req_addr = 32'h11; req_wdata = 32'h0000_00CD;
        @(posedge CLK); #1;
        req_valid = 1'b0;
        for (int i = 0; i < extra; i++) begin @(posedge CLK); #1; end
        if (extra == 0) check_eq("in_rd", mem_read, 1);
        else            check_eq("in_wr", mem_write, 1);
        #1 reset = 1'b1;
        #1 check_reset_outputs(extra == 0 ? "rst_rd" : "rst_wr");
        @(posedge CLK); #1;
        check_eq("rst_ram_intact", ram[4], mword(16));
        @(negedge CLK) reset = 1'b0;
    endtask

    initial begin
        #1 reset = 1'b1;
        #1 check_reset_outputs("por");
        for (int w = 0; w < 16; w++) init_word(w, (w == 4) ? 32'h1122_8344 : $urandom);
        @(negedge CLK) reset = 1'b0;

        do_req(1'b0, 2'd0, 1'b0, 32'h12, 32'd0, 0, 1'b0);
        do_req(1'b0, 2'd1, 1'b1, 32'h12, 32'd0, 0, 1'b0);
        do_req(1'b0, 2'd0, 1'b1, 32'h11, 32'd0, 0, 1'b0);
        do_req(1'b1, 2'd0, 1'b0, 32'h11, 32'h0000_00AB, 0, 1'b0);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 0, 1'b0);
        check_eq("rmw_ram_word", ram[4], 32'h11AB_8344);
        do_req(1'b0, 2'd2, 1'b0, 32'h12, 32'd0, 0, 1'b0);
        do_req(1'b0, 2'd3, 1'b0, 32'h10, 32'd0, 0, 1'b0);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 3, 1'b1);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 0, 1'b0);

        for (int t = 0; t < 80; t++)
            do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)),
                   $urandom, $urandom_range(0, 2), 1'b0);

        reset_mid(0);
        reset_mid(1);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 0, 1'b0);

        for (int w = 0; w < 16; w++) check_eq("final_ram", ram[w], mword(4*w));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
